// File: rtl/dmem_mmio_responder.sv
// Data-side memory responder: word RAM plus an MMIO page with a console FIFO and status.
// Define DMEM_CYCLE_CNT_EN to add a free-running cycle counter readable at MMIO offset 0x8.
module dmem_mmio_responder #(
    parameter int DEPTH      = 1024,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_out,
    input  logic        data_wr,
    output logic [31:0] data_in,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;

    localparam logic [13:0] OFF_CONSOLE = 14'd0;
    localparam logic [13:0] OFF_STAT    = 14'd1;
    localparam logic [13:0] OFF_CYCLE   = 14'd2;

    logic [31:0] mem [DEPTH];
    logic [7:0]  fifo_mem [FIFO_DEPTH];

    logic [FW-1:0] head_q, head_d;
    logic [FW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          ovf_q, ovf_d;

    logic          is_mmio;
    logic [13:0]   mmio_off;
    logic [AW-1:0] ram_idx;
    logic          ram_we;
    logic          push_req;
    logic          push_ok;
    logic          overflow;
    logic          pop;
    logic          stat_wr;
    logic          fifo_full;
    logic          fifo_empty;
    logic [15:0]   count16;
    logic [31:0]   cycle_rd;
    logic          unused_addr_bits;

    assign unused_addr_bits = ^data_addr[1:0];

    assign is_mmio  = (data_addr[31:16] == 16'hFFFF);
    assign mmio_off = data_addr[15:2];
    assign ram_idx  = data_addr[AW+1:2];
    assign ram_we   = data_wr && !is_mmio;

    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign count16    = 16'(count_q);

    assign tx_valid = !fifo_empty;
    assign tx_data  = fifo_mem[head_q];

    assign pop      = tx_valid && tx_ready;
    assign push_req = data_wr && is_mmio && (mmio_off == OFF_CONSOLE);
    assign stat_wr  = data_wr && is_mmio && (mmio_off == OFF_STAT);
    // A pop in the same cycle frees the slot the push is about to fill.
    assign push_ok  = push_req && (!fifo_full || pop);
    assign overflow = push_req && fifo_full && !pop;

`ifdef DMEM_CYCLE_CNT_EN
    logic [31:0] cycle_q, cycle_d;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cycle_q <= '0;
        end else begin
            cycle_q <= cycle_d;
        end
    end

    assign cycle_rd = cycle_q;
`else
    assign cycle_rd = '0;
`endif

    always_comb begin
        head_d  = head_q + FW'(pop);
        tail_d  = tail_q + FW'(push_ok);
        count_d = count_q + CW'(push_ok) - CW'(pop);
        ovf_d   = ovf_q;
        // An overflow in the same cycle as a clear must leave the flag set.
        if (overflow) begin
            ovf_d = 1'b1;
        end else if (stat_wr && data_out[18]) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage arrays carry no reset; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_idx] <= data_out;
        end
        if (push_ok) begin
            fifo_mem[tail_q] <= data_out[7:0];
        end
    end

    always_comb begin
        data_in = '0;
        if (is_mmio) begin
            case (mmio_off)
                OFF_CONSOLE: data_in = '0;
                OFF_STAT:    data_in = {13'b0, ovf_q, fifo_empty, fifo_full, count16};
                OFF_CYCLE:   data_in = cycle_rd;
                default:     data_in = '0;
            endcase
        end else begin
            data_in = mem[ram_idx];
        end
    end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Directed self-checking bench for dmem_mmio_responder (default DEPTH=1024, FIFO_DEPTH=16).
// Inputs change on the falling clock edge; outputs are checked away from the rising edge.
module tb_dmem_mmio_responder;

    localparam int DEPTH      = 1024;
    localparam int FIFO_DEPTH = 16;

    localparam logic [31:0] A_CONSOLE = 32'hFFFF_0000;
    localparam logic [31:0] A_STAT    = 32'hFFFF_0004;
    localparam logic [31:0] A_CYCLE   = 32'hFFFF_0008;

    logic        clk;
    logic        nrst;
    logic [31:0] data_addr;
    logic [31:0] data_out;
    logic        data_wr;
    logic [31:0] data_in;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    int checks = 0;
    int errors = 0;

    dmem_mmio_responder #(
        .DEPTH(DEPTH),
        .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .data_addr(data_addr),
        .data_out(data_out),
        .data_wr(data_wr),
        .data_in(data_in),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One store occupying exactly one rising edge; call on a falling edge.
    task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata);
        data_addr = addr;
        data_out  = wdata;
        data_wr   = 1'b1;
        @(negedge clk);
        data_wr   = 1'b0;
    endtask

    task automatic read_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        data_wr   = 1'b0;
        data_addr = addr;
        #1;
        check_output(tag, data_in, exp);
    endtask

    initial begin
        logic [7:0] drain_exp [16];
        logic [31:0] cycle_exp;

        nrst      = 1'b0;
        data_addr = '0;
        data_out  = '0;
        data_wr   = 1'b0;
        tx_ready  = 1'b0;
        $display("[TB] starting");

        repeat (2) @(negedge clk);
        check_output("reset_tx_valid", {31'b0, tx_valid}, 32'd0);
        read_check("reset_stat", A_STAT, 32'h0002_0000);

        // Release reset on a falling edge, then let five rising edges pass.
        @(negedge clk);
        nrst = 1'b1;
        repeat (5) @(negedge clk);
`ifdef DMEM_CYCLE_CNT_EN
        cycle_exp = 32'd5;
`else
        cycle_exp = 32'd0;
`endif
        read_check("cycle_after_reset", A_CYCLE, cycle_exp);

        // RAM store/load and aliasing
        apply_stimulus(32'h0000_0040, 32'hDEAD_BEEF);
        read_check("ram_rd_40", 32'h0000_0040, 32'hDEAD_BEEF);
        read_check("ram_alias", 32'h0000_0040 + DEPTH * 4, 32'hDEAD_BEEF);
        read_check("ram_alias_hi", 32'h8000_0040, 32'hDEAD_BEEF);

        // Read during write returns the old value
        apply_stimulus(32'h0000_0010, 32'h0000_0001);
        data_addr = 32'h0000_0010;
        data_out  = 32'h0000_0002;
        data_wr   = 1'b1;
        #1;
        check_output("rdw_old", data_in, 32'h0000_0001);
        @(negedge clk);
        data_wr = 1'b0;
        #1;
        check_output("rdw_new", data_in, 32'h0000_0002);
        read_check("console_reads_zero", A_CONSOLE, 32'd0);
        read_check("unmapped_reads_zero", 32'hFFFF_0010, 32'd0);

        // Console push then drain
        tx_ready = 1'b0;
        @(negedge clk);
        apply_stimulus(A_CONSOLE, 32'h0000_0041);
        check_output("push1_valid", {31'b0, tx_valid}, 32'd1);
        check_output("push1_head", {24'b0, tx_data}, 32'h41);
        apply_stimulus(A_CONSOLE, 32'hFFFF_FF42);
        read_check("stat_two", A_STAT, 32'h0000_0002);
        data_addr = 32'h0000_0000;
        tx_ready  = 1'b1;
        #1;
        check_output("drain_head0", {24'b0, tx_data}, 32'h41);
        @(negedge clk);
        check_output("drain_head1", {24'b0, tx_data}, 32'h42);
        check_output("drain_valid1", {31'b0, tx_valid}, 32'd1);
        @(negedge clk);
        check_output("drain_empty", {31'b0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
        read_check("stat_empty", A_STAT, 32'h0002_0000);

        // Overflow: FIFO_DEPTH+1 pushes with the consumer stalled
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            apply_stimulus(A_CONSOLE, 32'h60 + 32'(i));
        end
        read_check("stat_ovf", A_STAT, 32'h0005_0010);
        check_output("ovf_head", {24'b0, tx_data}, 32'h60);
        apply_stimulus(A_STAT, 32'h0004_0000);
        read_check("stat_ovf_clr", A_STAT, 32'h0001_0010);

        // Push while full with a simultaneous pop
        data_addr = A_CONSOLE;
        data_out  = 32'h0000_0055;
        data_wr   = 1'b1;
        tx_ready  = 1'b1;
        @(negedge clk);
        data_wr  = 1'b0;
        tx_ready = 1'b0;
        read_check("stat_full_pop", A_STAT, 32'h0001_0010);

        // Remaining order: 0x61..0x6F then 0x55; 0x70 was dropped
        for (int i = 0; i < 15; i++) drain_exp[i] = 8'h61 + 8'(i);
        drain_exp[15] = 8'h55;
        data_addr = 32'h0000_0000;
        tx_ready  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            check_output($sformatf("drain_full_%0d", i), {23'b0, tx_valid, tx_data},
                         {23'b0, 1'b1, drain_exp[i]});
            @(negedge clk);
        end
        check_output("drain_full_done", {31'b0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

        // Reset asserted mid-drain
        apply_stimulus(A_CONSOLE, 32'h0000_0011);
        apply_stimulus(A_CONSOLE, 32'h0000_0022);
        tx_ready = 1'b1;
        @(negedge clk);
        check_output("pre_reset_head", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'h22});
        #2;
        nrst = 1'b0;
        #1;
        check_output("reset_async_valid", {31'b0, tx_valid}, 32'd0);
        read_check("reset_mid_cycle", A_CYCLE, 32'd0);
        read_check("reset_mid_stat", A_STAT, 32'h0002_0000);
        read_check("ram_survives_reset", 32'h0000_0040, 32'hDEAD_BEEF);
        tx_ready = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        apply_stimulus(A_CONSOLE, 32'h0000_0077);
        check_output("post_reset_push", {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'h77});
        read_check("post_reset_stat", A_STAT, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_mmio_responder.md
# dmem_mmio_responder

Data-side memory responder for the pipelined MIPS core: answers the core's MEM-stage accesses (`data_addr`, `data_out`, `data_wr` in; `data_in` out) with a word RAM plus a small memory-mapped I/O page. The I/O page holds a byte console FIFO, drained by an external consumer through a valid/ready handshake, and a status register. Sits beside the instruction memory at the top level, wired directly to the core's data port.

## Interface
- `DEPTH`, 1024: RAM size in 32-bit words; power of two, ≥ 4.
- `FIFO_DEPTH`, 16: console FIFO entries; power of two, 2..65535.
- `clk`  in  1  single clock; all state updates on posedge.
- `nrst`  in  1  reset, asynchronous, active-low.
- `data_addr`  in  32  byte address from core; bits [1:0] ignored.
- `data_out`  in  32  store data from core.
- `data_wr`  in  1  store strobe; one store per cycle asserted.
- `data_in`  out  32  load data to core, combinational.
- `tx_data`  out  8  console FIFO head byte.
- `tx_valid`  out  1  FIFO non-empty.
- `tx_ready`  in  1  consumer accepts head when high with `tx_valid`.

## Operation
- Region select: `data_addr[31:16] == 16'hFFFF` selects MMIO; all other addresses select RAM.
- RAM index = `data_addr[log2(DEPTH)+1:2]`; higher bits are ignored, so the address space aliases modulo `DEPTH*4`.
- RAM read: `data_in = mem[index]`, combinational.
- RAM write: `mem[index] <= data_out` at posedge when `data_wr` is high.
- RAM contents are not reset.
- MMIO offsets (`data_addr[15:0]`, word-aligned):
  - 0x0 CONSOLE: write pushes `data_out[7:0]`; read returns 0.
  - 0x4 STAT: read `{13'b0, ovf[18], empty[17], full[16], count[15:0]}`; write with `data_out[18]=1` clears `ovf`, other bits ignored.
  - 0x8 CYCLE: see Configuration.
  - Any other offset: reads 0, writes ignored.
- FIFO push accepted when not full, or when full and a pop occurs in the same cycle (count unchanged).
- Push attempted while full with no pop: byte dropped and `ovf` set (sticky).
- Pop: `tx_valid && tx_ready`. Head pointer advances; pointers wrap modulo `FIFO_DEPTH`.
- `tx_valid = !empty`; `tx_data` = entry at head pointer (0 when empty is not required, don't-care).
- Simultaneous STAT write clearing `ovf` and an overflowing push: set wins, so `ovf` = 1.

## Timing
- Load latency 0: `data_in` is valid in the same cycle as `data_addr`, matching the core's MEM→WB capture.
- Store visible to reads from the cycle after the write edge. A same-cycle read of the address being written returns the old value.
- Push to empty FIFO: `tx_valid` rises one cycle after the write edge; there is no fall-through.
- STAT reads reflect the pre-edge state; a push in the same cycle is not counted.
- Reset values: FIFO pointers 0, count 0, `ovf` 0, `tx_valid` 0, CYCLE 0. `data_in` follows the address, so RAM reads are undefined until written.
- `nrst` asserted mid-operation empties the FIFO immediately (`tx_valid` drops asynchronously) and clears `ovf` and CYCLE; RAM is untouched.

## Configuration
- `DMEM_CYCLE_CNT_EN` defined:
  - 32-bit free-running counter; 0 at reset, +1 every posedge, wraps at 2^32.
  - Readable at offset 0x8, returning the pre-edge value; writes ignored.
- Not defined: no counter hardware; offset 0x8 reads 0.

## Test plan
- RAM write/read: store 0xDEADBEEF to 0x0000_0040, next cycle load 0x40 → `data_in`=0xDEADBEEF; load `0x40 + DEPTH*4` → same value (alias).
- Read-during-write: RAM[0x10] holds 0x1; in one cycle store 0x2 at 0x10 while sampling `data_in` → 0x1; next cycle → 0x2.
- Console push/drain: `tx_ready`=0, push 0x41, 0x42; STAT → count=2, empty=0. Raise `tx_ready` → `tx_data` 0x41 then 0x42 on consecutive cycles; then `tx_valid`=0, STAT empty=1.
- Overflow: hold `tx_ready`=0, push `FIFO_DEPTH+1` bytes → STAT full=1, ovf=1, count=`FIFO_DEPTH`; the last byte never appears on `tx_data`. Write STAT with bit18=1 → ovf=0.
- Full with simultaneous pop: FIFO full, `tx_ready`=1, push 0x55 → ovf stays 0, count stays `FIFO_DEPTH`, 0x55 emerges last.
- Reset and counter: with `DMEM_CYCLE_CNT_EN`, read 0x8 N cycles after reset release → N. Pulse `nrst` low mid-drain → `tx_valid`=0 immediately, CYCLE=0, previously written RAM data intact. Without the macro, 0x8 reads 0.
